// File: rtl/pipe_checker.sv
// pipe_checker: receiving-end scoreboard for a registered AND pipeline.
// Every accepted stimulus (valid_in) queues a&b in an in-order FIFO; every
// result (valid_out) pops the head and the pair is compared one cycle later.
// Optional feature macro: PIPE_CHECKER_LAT_EN adds per-entry cycle stamps and
// the lat_max / lat_min latency outputs.
module pipe_checker #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     valid_in,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  input  logic                     valid_out,
  input  logic [W-1:0]             out,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic                     overflow,
  output logic                     underflow,
  output logic [1:0]               state,
  output logic [W-1:0]             first_exp,
  output logic [W-1:0]             first_got,
  output logic [$clog2(DEPTH):0]   level
`ifdef PIPE_CHECKER_LAT_EN
  ,
  output logic [15:0]              lat_max,
  output logic [15:0]              lat_min
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FAIL = 2'b10
  } state_t;

  // FIFO storage and pointers (extra MSB is the wrap bit)
  logic [W-1:0]   r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  logic [W-1:0]   r_rd_data;

  // Registered compare stage: what happened at the previous edge
  logic           r_ev_pop;
  logic           r_ev_under;
  logic           r_ev_drop;
  logic [W-1:0]   r_ev_got;
  logic [W-1:0]   r_ev_drop_word;

  // Result registers
  logic [CNT_W-1:0] r_match_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_overflow;
  logic             r_underflow;
  logic [W-1:0]     r_first_exp;
  logic [W-1:0]     r_first_got;
  state_t           r_state;
  state_t           w_state_next;

  logic [AW:0]    w_level;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_under;
  logic           w_push;
  logic           w_drop;
  logic [W-1:0]   w_exp_in;
  logic           w_mismatch;
  logic           w_match;
  logic           w_err;
  logic           w_fail_ev;

  assign w_level  = r_wptr - r_rptr;
  assign w_full   = (w_level == (AW+1)'(DEPTH));
  assign w_empty  = (w_level == '0);
  assign w_pop    = valid_out && !w_empty;
  assign w_under  = valid_out && w_empty;
  // A pop in the same cycle frees the slot, so full+push+pop is legal
  assign w_push   = valid_in && (!w_full || w_pop);
  assign w_drop   = valid_in && w_full && !w_pop;
  assign w_exp_in = a & b;

  assign w_mismatch = r_ev_pop && (r_rd_data != r_ev_got);
  assign w_match    = r_ev_pop && (r_rd_data == r_ev_got);
  assign w_err      = w_mismatch || r_ev_under;
  assign w_fail_ev  = w_err || r_ev_drop;

  // FIFO RAM write plus read-first registered read of the head on pop
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_exp_in;
    end
    if (w_pop) begin
      r_rd_data <= r_mem[r_rptr[AW-1:0]];
    end
  end

  // Pointer update and capture of this cycle's events for the compare stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_ev_pop       <= 1'b0;
      r_ev_under     <= 1'b0;
      r_ev_drop      <= 1'b0;
      r_ev_got       <= '0;
      r_ev_drop_word <= '0;
    end else if (clear) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_ev_pop       <= 1'b0;
      r_ev_under     <= 1'b0;
      r_ev_drop      <= 1'b0;
      r_ev_got       <= '0;
      r_ev_drop_word <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      r_ev_pop       <= w_pop;
      r_ev_under     <= w_under;
      r_ev_drop      <= w_drop;
      r_ev_got       <= out;
      r_ev_drop_word <= w_exp_in;
    end
  end

  // Next-state logic: faults win over the first push; FAIL is absorbing
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fail_ev)     w_state_next = S_FAIL;
        else if (valid_in) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_fail_ev) w_state_next = S_FAIL;
      end
      S_FAIL: w_state_next = S_FAIL;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register, saturating counters, sticky flags and first-error capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_match && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + CNT_W'(1);
      if (w_err && (r_err_cnt != '1))     r_err_cnt   <= r_err_cnt + CNT_W'(1);
      if (r_ev_drop)  r_overflow  <= 1'b1;
      if (r_ev_under) r_underflow <= 1'b1;
      if (w_fail_ev && (r_state != S_FAIL)) begin
        if (w_err) begin
          // An underflow has no expected word, so it reports zero
          r_first_exp <= r_ev_under ? '0 : r_rd_data;
          r_first_got <= r_ev_got;
        end else begin
          // Overflow: report the dropped expected word, nothing received
          r_first_exp <= r_ev_drop_word;
          r_first_got <= '0;
        end
      end
    end
  end

`ifdef PIPE_CHECKER_LAT_EN
  logic [15:0] r_stamp_mem [DEPTH];
  logic [15:0] r_cycle;
  logic [15:0] r_rd_stamp;
  logic [15:0] r_ev_cycle;
  logic [15:0] r_lat_max;
  logic [15:0] r_lat_min;
  logic [15:0] w_lat;

  assign w_lat = r_ev_cycle - r_rd_stamp;

  // Stamp RAM written alongside the data word, read with the head on pop
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stamp_mem[r_wptr[AW-1:0]] <= r_cycle;
    end
    if (w_pop) begin
      r_rd_stamp <= r_stamp_mem[r_rptr[AW-1:0]];
    end
  end

  // Free-running stamp counter, pop-cycle capture and min/max tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle    <= '0;
      r_ev_cycle <= '0;
      r_lat_max  <= 16'h0000;
      r_lat_min  <= 16'hFFFF;
    end else begin
      r_cycle <= r_cycle + 16'd1;
      if (clear) begin
        r_ev_cycle <= '0;
        r_lat_max  <= 16'h0000;
        r_lat_min  <= 16'hFFFF;
      end else begin
        r_ev_cycle <= r_cycle;
        if (r_ev_pop) begin
          if (w_lat > r_lat_max) r_lat_max <= w_lat;
          if (w_lat < r_lat_min) r_lat_min <= w_lat;
        end
      end
    end
  end

  assign lat_max = r_lat_max;
  assign lat_min = r_lat_min;
`endif

  assign match_cnt = r_match_cnt;
  assign err_cnt   = r_err_cnt;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign state     = r_state;
  assign first_exp = r_first_exp;
  assign first_got = r_first_got;
  assign level     = w_level;

endmodule
